// File: rtl/mem_port_bridge_pkg.sv
// Shared memory-port types: request/response structs and line geometry.
package mem_port_bridge_pkg;

  localparam int MEM_LINE_BYTES = 64;
  localparam int MEM_DATA_WIDTH = 512;
  localparam int MEM_ADDR_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic                      isWrite;
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_ADDR_WIDTH-1:0] addr;
  } MemReq;

  typedef struct packed {
    logic                      valid;
    logic [MEM_DATA_WIDTH-1:0] data;
  } MemResp;

endpackage

// File: rtl/mem_port_bridge_fifo.sv
// Show-ahead FIFO: dout always presents the head entry while not empty.
// Push while full and pop while empty are ignored.
module mem_port_bridge_fifo #(
  parameter int WIDTH     = 1,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_bridge.sv
// Bridges the MMU MemReq/MemResp stream onto an Avalon-MM DRAM port.
// Every accepted request yields exactly one response, in acceptance order.
//
// Handshakes: a request transfers on a cycle where phy_mem_reqs.valid and
// phy_mem_req_grants are both high; a response transfers where
// phy_mem_resps.valid and phy_mem_resp_grants are both high. Grant/ready
// never depends on the partner's valid. An Avalon command completes on a
// cycle where avm_read|avm_write is high and avm_waitrequest is low.
module mem_port_bridge
  import mem_port_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_SHIFT      = $clog2(MEM_LINE_BYTES),
  parameter int AVM_ADDR_WIDTH  = MEM_ADDR_WIDTH - ADDR_SHIFT,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  MemReq                     phy_mem_reqs,
  output logic                      phy_mem_req_grants,
  output MemResp                    phy_mem_resps,
  input  logic                      phy_mem_resp_grants,
  output logic [AVM_ADDR_WIDTH-1:0] avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [MEM_DATA_WIDTH-1:0] avm_writedata,
  input  logic                      avm_waitrequest,
  input  logic                      avm_readdatavalid,
  input  logic [MEM_DATA_WIDTH-1:0] avm_readdata,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_unexpected_rd
);

  localparam int             LOG_DEPTH = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                      cmd_valid;
  logic                      cmd_is_write;
  logic [AVM_ADDR_WIDTH-1:0] cmd_addr;
  logic [MEM_DATA_WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0]          reads_pending;

  logic                      accept;
  logic                      issue;
  logic                      read_issue;
  logic                      rd_accept;
  logic                      resp_pop;
  logic                      head_is_write;
  logic                      order_empty;
  logic                      order_full;
  logic                      rdata_empty;
  logic                      rdata_full;
  logic [MEM_DATA_WIDTH-1:0] rdata_head;
  logic                      fifo_reset_n;
  logic                      unused_addr_bits;

  // Byte offset within a line is irrelevant to a line-addressed controller.
  assign unused_addr_bits = ^phy_mem_reqs.addr[ADDR_SHIFT-1:0];

  assign fifo_reset_n = ~rst;
  assign issue        = cmd_valid & ~avm_waitrequest;
  assign read_issue   = issue & ~cmd_is_write;
  // The command register frees up in the same cycle its command issues, so
  // accepts can stream at one per cycle while the controller keeps up.
  assign phy_mem_req_grants = (~cmd_valid | ~avm_waitrequest) & (outstanding < MAX_CNT) & ~rst;
  assign accept       = phy_mem_reqs.valid & phy_mem_req_grants;
  // Beats with no read pending are stale (e.g. after reset) and are dropped.
  assign rd_accept    = avm_readdatavalid & (reads_pending != '0);
  assign resp_pop     = phy_mem_resps.valid & phy_mem_resp_grants;

  assign avm_read      = cmd_valid & ~cmd_is_write;
  assign avm_write     = cmd_valid & cmd_is_write;
  assign avm_address   = cmd_addr;
  assign avm_writedata = cmd_data;

  // Response from the order FIFO head: writes ack at once, reads wait for data.
  always_comb begin
    phy_mem_resps = '0;
    if (!order_empty) begin
      if (head_is_write) begin
        phy_mem_resps.valid = 1'b1;
      end else begin
        phy_mem_resps.valid = ~rdata_empty;
        phy_mem_resps.data  = rdata_head;
      end
    end
  end

  // Single-entry command register; held unchanged while the controller stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid    <= 1'b0;
      cmd_is_write <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
    end else if (accept) begin
      cmd_valid    <= 1'b1;
      cmd_is_write <= phy_mem_reqs.isWrite;
      cmd_addr     <= phy_mem_reqs.addr[MEM_ADDR_WIDTH-1:ADDR_SHIFT];
      cmd_data     <= phy_mem_reqs.data;
    end else if (issue) begin
      cmd_valid    <= 1'b0;
    end
  end

  // Credit, pending-read and sticky error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding       <= '0;
      reads_pending     <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      case ({accept, resp_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      case ({read_issue, rd_accept})
        2'b10:   reads_pending <= reads_pending + 1'b1;
        2'b01:   reads_pending <= reads_pending - 1'b1;
        default: reads_pending <= reads_pending;
      endcase
      if (avm_readdatavalid && reads_pending == '0) err_unexpected_rd <= 1'b1;
    end
  end

  mem_port_bridge_fifo #(.WIDTH(1), .LOG_DEPTH(LOG_DEPTH)) u_order_fifo (
    .clk     (clk),
    .reset_n (fifo_reset_n),
    .push    (accept),
    .din     (phy_mem_reqs.isWrite),
    .pop     (resp_pop),
    .dout    (head_is_write),
    .empty   (order_empty),
    .full    (order_full)
  );

  mem_port_bridge_fifo #(.WIDTH(MEM_DATA_WIDTH), .LOG_DEPTH(LOG_DEPTH)) u_rdata_fifo (
    .clk     (clk),
    .reset_n (fifo_reset_n),
    .push    (rd_accept),
    .din     (avm_readdata),
    .pop     (resp_pop & ~head_is_write),
    .dout    (rdata_head),
    .empty   (rdata_empty),
    .full    (rdata_full)
  );

  a_out_bound:   assert property (@(posedge clk) disable iff (rst) outstanding <= MAX_CNT);
  a_rd_bound:    assert property (@(posedge clk) disable iff (rst) reads_pending <= outstanding);
  a_order_room:  assert property (@(posedge clk) disable iff (rst) !(accept && order_full));
  a_rdata_room:  assert property (@(posedge clk) disable iff (rst) !(rd_accept && rdata_full));

endmodule
